mmio_uart: RTL and testbench

- Memory-mapped UART responder on the core's valid/ready data bus: addr, size, valid, write, wdata, rdata, ready.
- Bus-side counterpart to the initiator the core presents. It replaces the ad-hoc tty_tx/tty_rx glue and address decode at 'h3000/'h3004.
- Serializes written bytes onto an 8N1 line, deserializes incoming 8N1 frames into an RX FIFO, and exposes a status register.
- Stdio reads block until a byte arrives; stdio writes block until the transmitter accepts the byte.

---
 rtl/mmio_uart.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart
//  Description : Memory-mapped 8N1 UART responder on a valid/ready data bus.
//                TXDATA (+0), RXDATA (+4, FIFO pop), STATUS (+8). TX writes
//                stall while the serializer is busy; RX reads stall while the
//                RX FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          CLK_DIV   = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx,
  input  logic        rx
);

  localparam int                  c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0]  c_div_half = c_div_w'(CLK_DIV / 2 - 1);
  localparam logic [c_div_w-1:0]  c_div_one  = c_div_w'(1);
  localparam int                  c_aw       = $clog2(RX_DEPTH);
  localparam logic [c_aw:0]       c_depth    = (c_aw + 1)'(RX_DEPTH);
  localparam logic [c_aw:0]       c_cnt_one  = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0]     c_ptr_one  = c_aw'(1);

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_WAITHI = 3'd4
  } rx_state_t;

  // Bus side
  bus_state_t          r_bus_state;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic [31:0]         w_rel;
  logic [3:0]          w_off;
  logic                w_sel;
  logic                w_is_tx;
  logic                w_is_rx;
  logic                w_is_st;
  logic                w_can;
  logic                w_accept;
  logic                w_tx_load;
  logic                w_pop;
  logic                w_flag_clr;
  logic [31:0]         w_rd_val;
  logic                w_unused;

  // TX serializer
  logic                r_tx;
  logic                r_tx_busy;
  logic [8:0]          r_tx_shift;
  logic [3:0]          r_tx_bitcnt;
  logic [c_div_w-1:0]  r_tx_div;

  // RX deserializer
  logic                r_rx_meta;
  logic                r_rx_sync;
  logic                r_rx_prev;
  rx_state_t           r_rx_state;
  logic [c_div_w-1:0]  r_rx_div;
  logic [2:0]          r_rx_bitcnt;
  logic [7:0]          r_rx_shift;
  logic                w_stop_sample;
  logic                w_rx_push;
  logic                w_fe_set;

  // RX FIFO and sticky flags
  logic [7:0]          r_fifo_mem [RX_DEPTH];
  logic [c_aw-1:0]     r_wr_ptr;
  logic [c_aw-1:0]     r_rd_ptr;
  logic [c_aw:0]       r_count;
  logic                r_frame_err;
  logic                r_rx_ovf;
  logic                w_rx_empty;
  logic                w_full;
  logic                w_push_ok;
  logic                w_ovf_set;

  // Access size and the upper write byte lanes carry no meaning here
  assign w_unused = ^{size, wdata[31:8]};

  // Window decode: unsigned offset from the base, in-window when below 16
  assign w_rel   = addr - BASE_ADDR;
  assign w_off   = w_rel[3:0];
  assign w_sel   = valid && (w_rel < 32'd16);
  assign w_is_tx = (w_off == 4'h0);
  assign w_is_rx = (w_off == 4'h4);
  assign w_is_st = (w_off == 4'h8);

  assign w_rx_empty = (r_count == '0);
  assign w_full     = (r_count == c_depth);

  // Only a TX write while busy or an RX read while empty has to wait
  assign w_can      = !((write && w_is_tx && r_tx_busy) ||
                        (!write && w_is_rx && w_rx_empty));
  assign w_accept   = (r_bus_state == BUS_IDLE) && w_sel && w_can;
  assign w_tx_load  = w_accept && write && w_is_tx;
  assign w_pop      = w_accept && !write && w_is_rx;
  assign w_flag_clr = w_accept && write && w_is_st;

  // Read value captured on the accepting edge
  always_comb begin
    w_rd_val = '0;
    if (!write) begin
      if (w_is_rx) begin
        w_rd_val = {24'b0, r_fifo_mem[r_rd_ptr]};
      end else if (w_is_st) begin
        w_rd_val = {28'b0, r_frame_err, r_rx_ovf, !w_rx_empty, r_tx_busy};
      end
    end
  end

  // Bus FSM: accept in IDLE, pulse ready in ACK, wait for valid to drop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_state <= BUS_IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_bus_state)
        BUS_IDLE: begin
          if (w_accept) begin
            r_bus_state <= BUS_ACK;
            r_ready     <= 1'b1;
            r_rdata     <= w_rd_val;
          end
        end
        BUS_ACK: begin
          r_bus_state <= BUS_WAIT;
          r_ready     <= 1'b0;
          r_rdata     <= '0;
        end
        BUS_WAIT: begin
          if (!valid) begin
            r_bus_state <= BUS_IDLE;
          end
        end
        default: begin
          r_bus_state <= BUS_IDLE;
          r_ready     <= 1'b0;
          r_rdata     <= '0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;

  // TX serializer: start bit driven straight from the load, then data LSB first and stop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_tx_shift  <= '1;
      r_tx_bitcnt <= '0;
      r_tx_div    <= '0;
    end else if (w_tx_load) begin
      r_tx        <= 1'b0;
      r_tx_busy   <= 1'b1;
      r_tx_shift  <= {1'b1, wdata[7:0]};
      r_tx_bitcnt <= '0;
      r_tx_div    <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_div == c_div_last) begin
        r_tx_div <= '0;
        if (r_tx_bitcnt == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx      <= 1'b1;
        end else begin
          r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
          r_tx        <= r_tx_shift[0];
          r_tx_shift  <= {1'b1, r_tx_shift[8:1]};
        end
      end else begin
        r_tx_div <= r_tx_div + c_div_one;
      end
    end
  end

  assign tx = r_tx;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_stop_sample = (r_rx_state == RX_STOP) && (r_rx_div == c_div_last);
  assign w_rx_push     = w_stop_sample && r_rx_sync;
  assign w_fe_set      = w_stop_sample && !r_rx_sync;

  // RX deserializer: confirm start at half-bit, then sample each bit at mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_div    <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_rx_div   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_div == c_div_half) begin
            r_rx_div <= '0;
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state  <= RX_DATA;
              r_rx_bitcnt <= '0;
            end
          end else begin
            r_rx_div <= r_rx_div + c_div_one;
          end
        end
        RX_DATA: begin
          if (r_rx_div == c_div_last) begin
            r_rx_div   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bitcnt == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
            end
          end else begin
            r_rx_div <= r_rx_div + c_div_one;
          end
        end
        RX_STOP: begin
          if (r_rx_div == c_div_last) begin
            r_rx_div   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_WAITHI;
          end else begin
            r_rx_div <= r_rx_div + c_div_one;
          end
        end
        RX_WAITHI: begin
          if (r_rx_sync) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge
  assign w_push_ok = w_rx_push && (!w_full || w_pop);
  assign w_ovf_set = w_rx_push && w_full && !w_pop;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_mem[r_wr_ptr] <= r_rx_shift;
    end
  end

  // FIFO pointers, occupancy and sticky flags (a new event beats a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      r_frame_err <= w_fe_set  || (r_frame_err && !w_flag_clr);
      r_rx_ovf    <= w_ovf_set || (r_rx_ovf && !w_flag_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart
//  Description : Directed self-checking bench for mmio_uart with a scoreboard
//                queue of expected read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart;

  localparam int c_div   = 16;
  localparam int c_depth = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        valid;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;
  logic        rx;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          lat;
  int          pulses;
  logic [9:0]  tx_frame;
  logic [31:0] exp_q [$];

  mmio_uart #(
    .BASE_ADDR (32'h0000_3000),
    .CLK_DIV   (c_div),
    .RX_DEPTH  (c_depth)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .size  (size),
    .valid (valid),
    .write (write),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ready was seen
  task automatic bus_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int max_cyc, output int l);
    logic [31:0] e;
    exp_q.push_back(exp_rd);
    addr  = a;
    write = w;
    wdata = d;
    valid = 1'b1;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (ready !== 1'b1 && l < max_cyc);
    e = exp_q.pop_front();
    if (ready === 1'b1) check($sformatf("rdata @%h", a), rdata, e);
    else                check($sformatf("ready timeout @%h", a), {31'b0, ready}, 32'd1);
    valid = 1'b0;
  endtask

  // Lets the responder pass through WAIT back to IDLE
  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (c_div) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    size  = 3'd2;
    valid = 1'b0;
    write = 1'b0;
    wdata = '0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset tx", {31'b0, tx}, 32'd1);
    rst = 1'b0;

    // STATUS after reset: zero, one-cycle latency
    bus_op(32'h3008, 1'b0, 32'd0, 32'd0, 10, lat);
    check("status latency", 32'(lat), 32'd1);
    check("tx idle", {31'b0, tx}, 32'd1);
    gap();

    // TX 'h48, then a second write that must stall for the whole frame
    tx_frame = {1'b1, 8'h48, 1'b0};
    bus_op(32'h3000, 1'b1, 32'hFFFF_FF48, 32'd0, 10, lat);
    check("tx write latency", 32'(lat), 32'd1);
    fork
      begin
        check("tx start after load", {31'b0, tx}, 32'd0);
        repeat (c_div / 2) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
          check($sformatf("tx bit %0d", b), {31'b0, tx}, {31'b0, tx_frame[b]});
          if (b < 9) repeat (c_div) @(negedge clk);
        end
      end
      begin
        gap();
        // load at edge 1, busy cleared at edge 161, accept at edge 162;
        // drive happened two negedges after the first ready
        bus_op(32'h3000, 1'b1, 32'h0000_00A5, 32'd0, 400, lat);
        check("stalled write latency", 32'(lat), 32'd159);
      end
    join
    gap();
    bus_op(32'h3008, 1'b0, 32'd0, 32'd1, 10, lat);
    repeat (170) @(negedge clk);
    check("tx idle after frames", {31'b0, tx}, 32'd1);

    // Blocking RXDATA read satisfied by an incoming 'h41 frame
    fork
      begin
        bus_op(32'h3004, 1'b0, 32'd0, 32'h0000_0041, 400, lat);
        check("rx read waits for stop sample", {31'b0, (lat >= 158 && lat <= 164)}, 32'd1);
      end
      begin
        repeat (5) @(negedge clk);
        send_frame(8'h41, 1'b1);
      end
    join
    gap();

    // RX_DEPTH+1 frames with no reads: last one overflows
    for (int i = 0; i <= c_depth; i++) send_frame(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    bus_op(32'h3008, 1'b0, 32'd0, 32'h0000_0006, 10, lat);
    gap();
    for (int i = 0; i < c_depth; i++) begin
      bus_op(32'h3004, 1'b0, 32'd0, 32'(i), 10, lat);
      gap();
    end
    check("rx pop latency", 32'(lat), 32'd1);
    bus_op(32'h3008, 1'b1, 32'd0, 32'd0, 10, lat);
    gap();
    bus_op(32'h3008, 1'b0, 32'd0, 32'd0, 10, lat);
    gap();

    // Framing error, then a good frame
    send_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    bus_op(32'h3008, 1'b0, 32'd0, 32'h0000_0008, 10, lat);
    gap();
    repeat (10) @(negedge clk);
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    bus_op(32'h3004, 1'b0, 32'd0, 32'h0000_0055, 10, lat);
    gap();
    bus_op(32'h3008, 1'b0, 32'd0, 32'h0000_0008, 10, lat);
    gap();
    bus_op(32'h3008, 1'b1, 32'd0, 32'd0, 10, lat);
    gap();

    // Reset in the middle of a TX frame of 'h00
    bus_op(32'h3000, 1'b1, 32'd0, 32'd0, 10, lat);
    gap();
    repeat (38) @(negedge clk);
    check("tx mid frame", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("tx after reset", {31'b0, tx}, 32'd1);
    check("ready after reset", {31'b0, ready}, 32'd0);
    rst = 1'b0;
    bus_op(32'h3008, 1'b0, 32'd0, 32'd0, 10, lat);
    gap();

    // Held valid on +C: exactly one ready pulse, read data zero
    pulses = 0;
    addr   = 32'h300C;
    write  = 1'b0;
    valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        check("+C rdata", rdata, 32'd0);
      end
    end
    valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    check("+C ready pulses", 32'(pulses), 32'd1);

    // Just outside the window on both sides: never ready
    pulses = 0;
    addr   = 32'h3010;
    valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    addr = 32'h2FFF;
    repeat (5) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    valid = 1'b0;
    check("out of window pulses", 32'(pulses), 32'd0);
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
